hazard_ctrl: RTL and testbench

Pipeline hazard controller for the three-stage core. Each cycle it computes the `flush`/`keep` controls for pipeline register 1 (IF/ID), pipeline register 2 (ID/EX) and pipeline register 3 (EX/WB), plus the PC hold. It resolves:
- load-use hazards;
- EX-stage redirects (taken branch or jump);
- multi-cycle data-memory accesses;
- a start/done handshake with the multiply/divide unit (MDU).

It also holds the pipeline flushed for a fixed number of cycles after reset and keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the three-stage core: stalls, flushes and MDU handshake.
// Control outputs are combinational; state and perf counters update on the rising edge.
module hazard_ctrl #(
    parameter int unsigned RESET_FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic        ex_mem_req,
    input  logic        mem_ready,
    input  logic        ex_mdu_op,
    input  logic        mdu_done,
    output logic        mdu_start,
    output logic        pc_keep,
    output logic        pipe1_flush,
    output logic        pipe1_keep,
    output logic        pipe2_flush,
    output logic        pipe2_keep,
    output logic        pipe3_flush,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic [1:0] {
        S_RESET_FLUSH = 2'd0,
        S_RUN         = 2'd1,
        S_MEM_WAIT    = 2'd2,
        S_MDU_WAIT    = 2'd3
    } state_t;

    localparam logic [3:0] RF_INIT = 4'(RESET_FLUSH_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rf_cnt;
    logic       flush_all;
    logic       freeze;
    logic       tail;
    logic       load_use;
    logic       redirect_taken;

    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // tail = "apply redirect / load-use / idle" (no memory or MDU stall this cycle)
    always_comb begin
        flush_all = 1'b0;
        freeze    = 1'b0;
        tail      = 1'b0;
        mdu_start = 1'b0;
        state_nxt = state;
        if (rst) begin
            flush_all = 1'b1;
            state_nxt = S_RESET_FLUSH;
        end else begin
            unique case (state)
                S_RESET_FLUSH: begin
                    flush_all = 1'b1;
                    if (rf_cnt <= 4'd1) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (ex_mem_req && !mem_ready) begin
                        freeze    = 1'b1;
                        state_nxt = S_MEM_WAIT;
                    end else if (ex_mdu_op) begin
                        freeze    = 1'b1;
                        mdu_start = 1'b1;
                        state_nxt = S_MDU_WAIT;
                    end else begin
                        tail = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (!mem_ready) begin
                        freeze = 1'b1;
                    end else begin
                        tail      = 1'b1;
                        state_nxt = S_RUN;
                    end
                end
                S_MDU_WAIT: begin
                    if (!mdu_done) begin
                        freeze = 1'b1;
                    end else begin
                        tail      = 1'b1;
                        state_nxt = S_RUN;
                    end
                end
                default: begin
                    flush_all = 1'b1;
                    state_nxt = S_RESET_FLUSH;
                end
            endcase
        end
    end

    always_comb begin
        redirect_taken = tail && ex_redirect;
        pc_keep     = flush_all || freeze ||
                      (tail && !ex_redirect && load_use);
        pipe1_flush = flush_all || redirect_taken;
        pipe1_keep  = freeze || (tail && !ex_redirect && load_use);
        pipe2_flush = flush_all || (tail && (ex_redirect || load_use));
        pipe2_keep  = freeze;
        pipe3_flush = flush_all || freeze;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RESET_FLUSH;
            rf_cnt       <= RF_INIT;
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_RESET_FLUSH) rf_cnt <= rf_cnt - 4'd1;
            if ((state != S_RESET_FLUSH) && pc_keep &&
                (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (redirect_taken && (flush_events != 32'hFFFF_FFFF))
                flush_events <= flush_events + 32'd1;
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus
// compared every cycle against a flag-based behavioural model.
module tb_hazard_ctrl;

    localparam int N_RF = 3;
    // {mdu_start, pc_keep, p1_flush, p1_keep, p2_flush, p2_keep, p3_flush}
    localparam logic [6:0] O_FLUSH  = 7'b0110101;
    localparam logic [6:0] O_FREEZE = 7'b0101011;
    localparam logic [6:0] O_START  = 7'b1101011;
    localparam logic [6:0] O_REDIR  = 7'b0010100;
    localparam logic [6:0] O_LDUSE  = 7'b0101100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_is_load = 0;
    logic ex_redirect = 0, ex_mem_req = 0, mem_ready = 0;
    logic ex_mdu_op = 0, mdu_done = 0;
    logic mdu_start, pc_keep, pipe1_flush, pipe1_keep;
    logic pipe2_flush, pipe2_keep, pipe3_flush;
    logic [1:0] ctrl_state;
    logic [31:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    hazard_ctrl #(.RESET_FLUSH_CYCLES(N_RF)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .ex_mem_req(ex_mem_req),
        .mem_ready(mem_ready), .ex_mdu_op(ex_mdu_op),
        .mdu_done(mdu_done), .mdu_start(mdu_start),
        .pc_keep(pc_keep),
        .pipe1_flush(pipe1_flush), .pipe1_keep(pipe1_keep),
        .pipe2_flush(pipe2_flush), .pipe2_keep(pipe2_keep),
        .pipe3_flush(pipe3_flush), .ctrl_state(ctrl_state),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    int tests = 0;
    int fails = 0;

    // model state: flush cycles left, waiting flags, counters
    bit     m_known = 0;
    int     m_rf = 0;
    bit     m_mem = 0, m_mdu = 0;
    longint m_stall = 0, m_flush = 0;

    logic [6:0]  cap_out;
    logic [1:0]  cap_state;
    logic [31:0] cap_stall, cap_flush;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit is_load_use();
        return ex_is_load && ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) ||
                (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    // One cycle: inputs already driven; check mid-cycle, then advance model.
    task automatic step();
        logic [6:0] e;
        bit applied, go_mem, go_mdu, rel;
        applied = 0; go_mem = 0; go_mdu = 0; rel = 0;
        @(negedge clk);
        if (rst || m_rf > 0) e = O_FLUSH;
        else if (m_mem && !mem_ready) e = O_FREEZE;
        else if (m_mdu && !mdu_done) e = O_FREEZE;
        else if (!m_mem && !m_mdu && ex_mem_req && !mem_ready) begin
            e = O_FREEZE; go_mem = 1;
        end else if (!m_mem && !m_mdu && ex_mdu_op) begin
            e = O_START; go_mdu = 1;
        end else begin
            rel = 1;
            if (ex_redirect) begin e = O_REDIR; applied = 1; end
            else if (is_load_use()) e = O_LDUSE;
            else e = '0;
        end
        cap_out = {mdu_start, pc_keep, pipe1_flush, pipe1_keep,
                   pipe2_flush, pipe2_keep, pipe3_flush};
        cap_state = ctrl_state;
        cap_stall = stall_cycles;
        cap_flush = flush_events;
        chk("ctrl_outputs", {25'd0, cap_out}, {25'd0, e});
        chk("flush_keep_excl",
            {30'd0, pipe1_flush & pipe1_keep, pipe2_flush & pipe2_keep}, 0);
        if (m_known) begin
            chk("ctrl_state", {30'd0, cap_state},
                m_rf > 0 ? 0 : m_mem ? 2 : m_mdu ? 3 : 1);
            chk("stall_cycles", cap_stall, m_stall[31:0]);
            chk("flush_events", cap_flush, m_flush[31:0]);
        end
        @(posedge clk);
        if (rst) begin
            m_known = 1; m_rf = N_RF; m_mem = 0; m_mdu = 0;
            m_stall = 0; m_flush = 0;
        end else if (m_rf > 0) begin
            m_rf--;
        end else begin
            if (e[5] && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (applied && m_flush < 64'hFFFF_FFFF) m_flush++;
            if (rel) begin m_mem = 0; m_mdu = 0; end
            if (go_mem) m_mem = 1;
            if (go_mdu) m_mdu = 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0;
        ex_redirect = 0; ex_mem_req = 0; mem_ready = 0;
        ex_mdu_op = 0; mdu_done = 0;
    endtask

    task automatic reset_to_run();
        idle_inputs();
        rst = 1; step(); step();
        rst = 0;
        for (int i = 0; i < N_RF; i++) step();
    endtask

    int starts, frozen;

    initial begin
        // reset flush
        idle_inputs();
        rst = 1; step(); step();
        rst = 0;
        for (int i = 0; i < N_RF; i++) begin
            step();
            chk("rf_flush_out", {25'd0, cap_out}, {25'd0, O_FLUSH});
        end
        step();
        chk("rf_state_run", {30'd0, cap_state}, 1);
        chk("rf_stall_zero", cap_stall, 0);
        chk("rf_flush_zero", cap_flush, 0);

        // load-use, then ex_rd = 0
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        step();
        chk("lu_out", {25'd0, cap_out}, {25'd0, O_LDUSE});
        idle_inputs(); step();
        chk("lu_stall1", cap_stall, 1);
        ex_is_load = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
        step();
        chk("lu_rd0_out", {25'd0, cap_out}, 0);
        idle_inputs(); step();
        chk("lu_rd0_stall", cap_stall, 1);

        // redirect over load-use
        reset_to_run();
        ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1;
        ex_redirect = 1;
        step();
        chk("redir_out", {25'd0, cap_out}, {25'd0, O_REDIR});
        idle_inputs(); step();
        chk("redir_count", cap_flush, 1);

        // memory wait with a redirect pulse mid-wait
        reset_to_run();
        ex_mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            ex_redirect = (i == 2);
            step();
            chk("mem_freeze", {25'd0, cap_out}, {25'd0, O_FREEZE});
        end
        ex_redirect = 0; mem_ready = 1;
        step();
        chk("mem_release", {25'd0, cap_out}, 0);
        idle_inputs(); step();
        chk("mem_stall4", cap_stall, 4);
        chk("mem_no_redir", cap_flush, 0);

        // MDU handshake, done on the 8th cycle
        reset_to_run();
        ex_mdu_op = 1; starts = 0; frozen = 0;
        for (int i = 0; i < 8; i++) begin
            mdu_done = (i == 7);
            step();
            starts += int'(cap_out[6]);
            frozen += int'(cap_out == O_FREEZE || cap_out == O_START);
        end
        chk("mdu_release", {25'd0, cap_out}, 0);
        idle_inputs(); step();
        chk("mdu_starts", starts, 1);
        chk("mdu_frozen", frozen, 7);
        chk("mdu_stall7", cap_stall, 7);

        // reset in the 3rd MDU wait cycle, stale done in RESET_FLUSH
        reset_to_run();
        ex_mdu_op = 1; step(); step(); step();
        rst = 1; step();
        chk("mdu_rst_out", {25'd0, cap_out}, {25'd0, O_FLUSH});
        rst = 0; ex_mdu_op = 0; starts = 0;
        for (int i = 0; i < N_RF; i++) begin
            mdu_done = (i == 1);
            step();
            starts += int'(cap_out[6]);
        end
        mdu_done = 0; step();
        chk("mdu_rst_nostart", starts, 0);
        chk("mdu_rst_state", {30'd0, cap_state}, 1);
        chk("mdu_rst_stall", cap_stall, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom);
            id_uses_rs2 = 1'($urandom);
            ex_is_load  = 1'($urandom);
            ex_redirect = ($urandom_range(0, 3) == 0);
            ex_mem_req  = ($urandom_range(0, 3) == 0);
            mem_ready   = 1'($urandom);
            ex_mdu_op   = ($urandom_range(0, 5) == 0);
            mdu_done    = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
